// File: rtl/frame_buffer_pingpong.sv
// -----------------------------------------------------------------------------
// frame_buffer_pingpong
//
// Double-buffered (ping-pong) pixel frame store. A raster writer fills one bank
// with an auto-incrementing address while the consumer randomly reads the other,
// previously completed bank. Banks swap only at frame boundaries, so the
// consumer never observes a torn frame.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   w_valid      write pixel valid
//   w_sof        start-of-frame marker, qualified by w_valid
//   w_data       write pixel
//   w_ready      writer may transfer this cycle (low while a finished frame waits)
//   r_en         read request
//   r_add        read address into the completed frame
//   r_data       read data, one cycle after r_en
//   r_valid      r_data valid (1-cycle pulse)
//   r_release    consumer done with the current frame
//   frame_avail  read bank holds a complete, unreleased frame
//   frame_done   1-cycle pulse: a bank swap occurred
//   sync_err     1-cycle pulse: w_sof arrived mid-frame
// -----------------------------------------------------------------------------
module frame_buffer_pingpong #(
    parameter int IMAGE_WIDTH  = 4,
    parameter int IMAGE_HEIGHT = 4,
    parameter int PIXEL_WIDTH  = 12,
    localparam int DEPTH = IMAGE_WIDTH * IMAGE_HEIGHT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   w_valid,
    input  logic                   w_sof,
    input  logic [PIXEL_WIDTH-1:0] w_data,
    output logic                   w_ready,
    input  logic                   r_en,
    input  logic [AW-1:0]          r_add,
    output logic [PIXEL_WIDTH-1:0] r_data,
    output logic                   r_valid,
    input  logic                   r_release,
    output logic                   frame_avail,
    output logic                   frame_done,
    output logic                   sync_err
);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_e;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    // One extra bit so the range test also works when DEPTH is a power of two.
    localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

    state_e                   state_q, state_d;
    logic                     wr_bank_q, wr_bank_d;
    logic [AW-1:0]            w_cnt_q, w_cnt_d;
    logic                     w_ready_q, w_ready_d;
    logic                     frame_avail_q, frame_avail_d;
    logic                     frame_done_q, frame_done_d;
    logic                     sync_err_q, sync_err_d;
    logic                     r_valid_q, r_valid_d;
    logic [PIXEL_WIDTH-1:0]   r_data_q, r_data_d;

    logic                     xfer_s;
    logic                     swap_ok_s;
    logic                     swap_s;
    logic                     mem_we_s;
    logic [AW-1:0]            mem_waddr_s;
    logic                     rd_bank_s;

    // Pixel storage, two banks; contents are intentionally not reset.
    logic [PIXEL_WIDTH-1:0]   mem_q [0:1][0:DEPTH-1];

    assign rd_bank_s = ~wr_bank_q;

    // Write FSM next-state: address counter, frame completion and bank swap.
    always_comb begin
        state_d       = state_q;
        wr_bank_d     = wr_bank_q;
        w_cnt_d       = w_cnt_q;
        frame_avail_d = frame_avail_q;
        frame_done_d  = 1'b0;
        sync_err_d    = 1'b0;
        mem_we_s      = 1'b0;
        mem_waddr_s   = w_cnt_q;
        swap_s        = 1'b0;
        swap_ok_s     = ~frame_avail_q | r_release;
        xfer_s        = w_valid & w_ready_q;

        case (state_q)
            ST_FILL: begin
                if (xfer_s) begin
                    mem_we_s = 1'b1;
                    if (w_sof) begin
                        // Resynchronise: the marker pixel always lands at address 0.
                        mem_waddr_s = '0;
                        w_cnt_d     = AW'(1);
                        sync_err_d  = (w_cnt_q != '0);
                    end else if (w_cnt_q == LAST_ADDR) begin
                        w_cnt_d = '0;
                        if (swap_ok_s) begin
                            swap_s = 1'b1;
                        end else begin
                            state_d = ST_FULL;
                        end
                    end else begin
                        w_cnt_d = w_cnt_q + AW'(1);
                    end
                end else begin
                    w_cnt_d = w_cnt_q;
                end
            end
            ST_FULL: begin
                w_cnt_d = '0;
                if (swap_ok_s) begin
                    swap_s  = 1'b1;
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_FILL;
                w_cnt_d = '0;
            end
        endcase

        // A swap consumes any same-cycle release; frame_avail stays set.
        if (swap_s) begin
            wr_bank_d     = ~wr_bank_q;
            frame_avail_d = 1'b1;
            frame_done_d  = 1'b1;
        end else if (r_release) begin
            frame_avail_d = 1'b0;
        end else begin
            frame_avail_d = frame_avail_q;
        end

        // Registered ready tracks the state we are about to enter.
        w_ready_d = (state_d == ST_FILL);
    end

    // Read port next-state: one-cycle latency, zero for addresses beyond the frame.
    always_comb begin
        r_valid_d = r_en;
        r_data_d  = r_data_q;
        if (r_en) begin
            if ({1'b0, r_add} < DEPTH_EXT) begin
                r_data_d = mem_q[rd_bank_s][r_add];
            end else begin
                r_data_d = '0;
            end
        end else begin
            r_data_d = r_data_q;
        end
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_FILL;
            wr_bank_q     <= 1'b0;
            w_cnt_q       <= '0;
            w_ready_q     <= 1'b1;
            frame_avail_q <= 1'b0;
            frame_done_q  <= 1'b0;
            sync_err_q    <= 1'b0;
            r_valid_q     <= 1'b0;
            r_data_q      <= '0;
        end else begin
            state_q       <= state_d;
            wr_bank_q     <= wr_bank_d;
            w_cnt_q       <= w_cnt_d;
            w_ready_q     <= w_ready_d;
            frame_avail_q <= frame_avail_d;
            frame_done_q  <= frame_done_d;
            sync_err_q    <= sync_err_d;
            r_valid_q     <= r_valid_d;
            r_data_q      <= r_data_d;
        end
    end

    // Pixel array write; blocked while reset is held.
    always_ff @(posedge clk) begin
        if (mem_we_s && !rst) begin
            mem_q[wr_bank_q][mem_waddr_s] <= w_data;
        end
    end

    assign w_ready     = w_ready_q;
    assign r_data      = r_data_q;
    assign r_valid     = r_valid_q;
    assign frame_avail = frame_avail_q;
    assign frame_done  = frame_done_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// -----------------------------------------------------------------------------
// tb_frame_buffer_pingpong
//
// Self-checking bench. A frame-level reference model (whole frames copied
// between "being written", "waiting" and "shown" arrays) predicts every output
// one cycle at a time. A second instance exercises a 5x3 (non power of two)
// frame geometry with directed checks.
// -----------------------------------------------------------------------------
module tb_frame_buffer_pingpong;

    localparam int PW = 12;
    localparam int ND = 16;

    logic          clk = 1'b0;
    logic          rst;

    // 4x4 instance
    logic          w_valid, w_sof, w_ready;
    logic [PW-1:0] w_data;
    logic          r_en, r_valid, r_release;
    logic [3:0]    r_add;
    logic [PW-1:0] r_data;
    logic          frame_avail, frame_done, sync_err;

    // 5x3 instance
    logic          o_w_valid, o_w_sof, o_w_ready;
    logic [PW-1:0] o_w_data;
    logic          o_r_en, o_r_valid, o_r_release;
    logic [3:0]    o_r_add;
    logic [PW-1:0] o_r_data;
    logic          o_frame_avail, o_frame_done, o_sync_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [PW-1:0] m_cur   [ND];
    logic [PW-1:0] m_held  [ND];
    logic [PW-1:0] m_shown [ND];
    int            m_pos;
    bit            m_held_v, m_avail, m_known;
    bit            m_rvalid, m_done, m_serr, m_rd_known;
    logic [PW-1:0] m_rdata;

    logic [4:0]    got_f, exp_f;

    always #5 clk = ~clk;

    frame_buffer_pingpong #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .PIXEL_WIDTH(PW)) dut (
        .clk(clk), .rst(rst),
        .w_valid(w_valid), .w_sof(w_sof), .w_data(w_data), .w_ready(w_ready),
        .r_en(r_en), .r_add(r_add), .r_data(r_data), .r_valid(r_valid),
        .r_release(r_release), .frame_avail(frame_avail),
        .frame_done(frame_done), .sync_err(sync_err)
    );

    frame_buffer_pingpong #(.IMAGE_WIDTH(5), .IMAGE_HEIGHT(3), .PIXEL_WIDTH(PW)) dut5 (
        .clk(clk), .rst(rst),
        .w_valid(o_w_valid), .w_sof(o_w_sof), .w_data(o_w_data), .w_ready(o_w_ready),
        .r_en(o_r_en), .r_add(o_r_add), .r_data(o_r_data), .r_valid(o_r_valid),
        .r_release(o_r_release), .frame_avail(o_frame_avail),
        .frame_done(o_frame_done), .sync_err(o_sync_err)
    );

    task automatic model_reset();
        m_pos      = 0;
        m_held_v   = 1'b0;
        m_avail    = 1'b0;
        m_known    = 1'b0;
        m_rvalid   = 1'b0;
        m_done     = 1'b0;
        m_serr     = 1'b0;
        m_rdata    = '0;
        m_rd_known = 1'b1;
    endtask

    // Frame-level behaviour for one clock, using the inputs currently driven.
    task automatic model_step();
        bit sw;
        sw = 1'b0;
        if (r_en) begin
            m_rvalid   = 1'b1;
            m_rdata    = m_shown[r_add];
            m_rd_known = m_known;
        end else begin
            m_rvalid = 1'b0;
        end
        m_serr = 1'b0;
        if (m_held_v) begin
            if (!m_avail || r_release) begin
                m_shown  = m_held;
                m_held_v = 1'b0;
                sw       = 1'b1;
            end
        end else if (w_valid) begin
            if (w_sof) begin
                m_serr   = (m_pos != 0);
                m_cur[0] = w_data;
                m_pos    = 1;
            end else begin
                m_cur[m_pos] = w_data;
                m_pos++;
                if (m_pos == ND) begin
                    m_pos = 0;
                    if (!m_avail || r_release) begin
                        m_shown = m_cur;
                        sw      = 1'b1;
                    end else begin
                        m_held   = m_cur;
                        m_held_v = 1'b1;
                    end
                end
            end
        end
        if (sw) begin
            m_avail = 1'b1;
            m_known = 1'b1;
        end else if (r_release) begin
            m_avail = 1'b0;
        end
        m_done = sw;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        w_valid = 1'b0; w_sof = 1'b0; w_data = '0;
        r_en = 1'b0; r_add = '0; r_release = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({w_ready, r_valid, frame_done, frame_avail, sync_err, r_data} !== {1'b1, 4'b0000, 12'h000}) begin
            errors++;
            $display("FAIL reset_outputs got %b/%h required 10000/000",
                     {w_ready, r_valid, frame_done, frame_avail, sync_err}, r_data);
        end
        checks++;
        if ({o_w_ready, o_r_valid, o_frame_done, o_frame_avail, o_sync_err, o_r_data} !== {1'b1, 4'b0000, 12'h000}) begin
            errors++;
            $display("FAIL reset_outputs_5x3 got %b/%h required 10000/000",
                     {o_w_ready, o_r_valid, o_frame_done, o_frame_avail, o_sync_err}, o_r_data);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_frame();
        for (int i = 0; i < ND; i++) begin
            w_valid = 1'b1; w_sof = (i == 0); w_data = PW'(i + 1);
            tick();
            got_f = {w_ready, r_valid, frame_done, frame_avail, sync_err};
            exp_f = {~m_held_v, m_rvalid, m_done, m_avail, m_serr};
            checks++;
            if (got_f !== exp_f) begin
                errors++;
                $display("FAIL t1_flags px%0d got %b required %b", i, got_f, exp_f);
            end
            if (i == ND - 1) begin
                checks++;
                if ({frame_done, frame_avail} !== 2'b11) begin
                    errors++;
                    $display("FAIL t1_swap got done/avail %b required 11", {frame_done, frame_avail});
                end
            end
        end
        idle_inputs();
        for (int i = 0; i < ND; i++) begin
            r_en = 1'b1; r_add = 4'(i);
            tick();
            checks++;
            if ({r_valid, r_data} !== {1'b1, PW'(i + 1)}) begin
                errors++;
                $display("FAIL t1_read addr%0d got %b/%h required 1/%h", i, r_valid, r_data, PW'(i + 1));
            end
        end
        idle_inputs();
    endtask

    task automatic test_full_hold();
        for (int i = 0; i < ND; i++) begin
            w_valid = 1'b1; w_sof = (i == 0); w_data = PW'(12'h100 + i);
            r_en = 1'b1; r_add = 4'(15 - i);
            tick();
            got_f = {w_ready, r_valid, frame_done, frame_avail, sync_err};
            exp_f = {~m_held_v, m_rvalid, m_done, m_avail, m_serr};
            checks++;
            if (got_f !== exp_f) begin
                errors++;
                $display("FAIL t2_flags px%0d got %b required %b", i, got_f, exp_f);
            end
            checks++;
            if (r_data !== PW'(16 - i)) begin
                errors++;
                $display("FAIL t2_old_frame addr%0d got %h required %h", 15 - i, r_data, PW'(16 - i));
            end
        end
        checks++;
        if (w_ready !== 1'b0) begin
            errors++;
            $display("FAIL t2_full_ready got %b required 0", w_ready);
        end
        // Writer keeps pushing while FULL; everything must be ignored.
        r_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w_valid = 1'b1; w_sof = 1'b1; w_data = 12'hFFF;
            tick();
            got_f = {w_ready, r_valid, frame_done, frame_avail, sync_err};
            exp_f = {~m_held_v, m_rvalid, m_done, m_avail, m_serr};
            checks++;
            if (got_f !== exp_f) begin
                errors++;
                $display("FAIL t2_hold cyc%0d got %b required %b", i, got_f, exp_f);
            end
        end
        idle_inputs();
        r_release = 1'b1;
        tick();
        r_release = 1'b0;
        checks++;
        if ({w_ready, frame_done, frame_avail} !== 3'b111) begin
            errors++;
            $display("FAIL t2_release_swap got %b required 111", {w_ready, frame_done, frame_avail});
        end
        for (int i = 0; i < ND; i++) begin
            r_en = 1'b1; r_add = 4'(i);
            tick();
            checks++;
            if ({r_valid, r_data} !== {1'b1, PW'(12'h100 + i)}) begin
                errors++;
                $display("FAIL t2_read addr%0d got %b/%h required 1/%h", i, r_valid, r_data, PW'(12'h100 + i));
            end
        end
        idle_inputs();
    endtask

    task automatic test_release_on_last();
        for (int i = 0; i < ND; i++) begin
            w_valid = 1'b1; w_sof = (i == 0); w_data = PW'(12'h200 + i);
            r_release = (i == ND - 1);
            tick();
            got_f = {w_ready, r_valid, frame_done, frame_avail, sync_err};
            exp_f = {~m_held_v, m_rvalid, m_done, m_avail, m_serr};
            checks++;
            if (got_f !== exp_f) begin
                errors++;
                $display("FAIL t3_flags px%0d got %b required %b", i, got_f, exp_f);
            end
        end
        checks++;
        if ({w_ready, frame_done, frame_avail} !== 3'b111) begin
            errors++;
            $display("FAIL t3_immediate_swap got %b required 111", {w_ready, frame_done, frame_avail});
        end
        idle_inputs();
        for (int i = 0; i < ND; i += 5) begin
            r_en = 1'b1; r_add = 4'(i);
            tick();
            checks++;
            if (r_data !== PW'(12'h200 + i)) begin
                errors++;
                $display("FAIL t3_read addr%0d got %h required %h", i, r_data, PW'(12'h200 + i));
            end
        end
        idle_inputs();
    endtask

    task automatic test_sync_err();
        int serr_cnt;
        serr_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            w_valid = 1'b1;
            w_sof   = (i == 0) || (i == 4);
            w_data  = (i < 4) ? PW'(12'h3F0 + i) : PW'(12'h300 + i - 4);
            r_release = (i == 19);
            tick();
            if (sync_err === 1'b1) serr_cnt++;
            got_f = {w_ready, r_valid, frame_done, frame_avail, sync_err};
            exp_f = {~m_held_v, m_rvalid, m_done, m_avail, m_serr};
            checks++;
            if (got_f !== exp_f) begin
                errors++;
                $display("FAIL t4_flags px%0d got %b required %b", i, got_f, exp_f);
            end
        end
        checks++;
        if (serr_cnt != 1 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL t4_sync_pulses got %0d/done %b required 1/1", serr_cnt, frame_done);
        end
        idle_inputs();
        for (int i = 0; i < ND; i++) begin
            r_en = 1'b1; r_add = 4'(i);
            tick();
            checks++;
            if (r_data !== PW'(12'h300 + i)) begin
                errors++;
                $display("FAIL t4_read addr%0d got %h required %h", i, r_data, PW'(12'h300 + i));
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            w_valid   = ($urandom_range(0, 9) < 7);
            w_sof     = (m_pos == 0) ? 1'b1 : ($urandom_range(0, 24) == 0);
            w_data    = PW'($urandom);
            r_en      = ($urandom_range(0, 1) == 1);
            r_add     = 4'($urandom_range(0, 15));
            r_release = ($urandom_range(0, 9) == 0);
            tick();
            got_f = {w_ready, r_valid, frame_done, frame_avail, sync_err};
            exp_f = {~m_held_v, m_rvalid, m_done, m_avail, m_serr};
            checks++;
            if (got_f !== exp_f) begin
                errors++;
                $display("FAIL rand_flags cyc%0d got %b required %b", c, got_f, exp_f);
            end
            if (m_rd_known) begin
                checks++;
                if (r_data !== m_rdata) begin
                    errors++;
                    $display("FAIL rand_data cyc%0d got %h required %h", c, r_data, m_rdata);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        int n_px;
        for (int k = 0; k < 2; k++) begin
            // k=0: stop mid-frame after 7 px; k=1: one swapped frame, then a held one (FULL).
            n_px = (k == 0) ? 7 : 2 * ND;
            for (int i = 0; i < n_px; i++) begin
                w_valid = 1'b1; w_sof = ((i % ND) == 0); w_data = PW'(12'h400 + i);
                tick();
                got_f = {w_ready, r_valid, frame_done, frame_avail, sync_err};
                exp_f = {~m_held_v, m_rvalid, m_done, m_avail, m_serr};
                checks++;
                if (got_f !== exp_f) begin
                    errors++;
                    $display("FAIL t6_pre k%0d px%0d got %b required %b", k, i, got_f, exp_f);
                end
            end
            idle_inputs();
            #2;
            rst = 1'b1;
            #1;
            checks++;
            if ({w_ready, r_valid, frame_done, frame_avail, sync_err, r_data} !== {1'b1, 4'b0000, 12'h000}) begin
                errors++;
                $display("FAIL t6_async_reset k%0d got %b/%h required 10000/000", k,
                         {w_ready, r_valid, frame_done, frame_avail, sync_err}, r_data);
            end
            model_reset();
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
        end
        for (int i = 0; i < ND; i++) begin
            w_valid = 1'b1; w_sof = (i == 0); w_data = PW'(12'h500 + i);
            tick();
            got_f = {w_ready, r_valid, frame_done, frame_avail, sync_err};
            exp_f = {~m_held_v, m_rvalid, m_done, m_avail, m_serr};
            checks++;
            if (got_f !== exp_f) begin
                errors++;
                $display("FAIL t6_post px%0d got %b required %b", i, got_f, exp_f);
            end
            checks++;
            if (frame_avail !== (i == ND - 1)) begin
                errors++;
                $display("FAIL t6_avail px%0d got %b required %b", i, frame_avail, (i == ND - 1));
            end
        end
        idle_inputs();
        for (int i = 0; i < ND; i++) begin
            r_en = 1'b1; r_add = 4'(i);
            tick();
            checks++;
            if (r_data !== PW'(12'h500 + i)) begin
                errors++;
                $display("FAIL t6_read addr%0d got %h required %h", i, r_data, PW'(12'h500 + i));
            end
        end
        idle_inputs();
    endtask

    task automatic test_odd_depth();
        for (int i = 0; i < 15; i++) begin
            o_w_valid = 1'b1; o_w_sof = (i == 0); o_w_data = PW'(12'h700 + i);
            @(posedge clk);
            #1;
            checks++;
            if ({o_w_ready, o_frame_done, o_frame_avail, o_sync_err} !== {1'b1, (i == 14), (i == 14), 1'b0}) begin
                errors++;
                $display("FAIL t5_stream px%0d got %b required %b", i,
                         {o_w_ready, o_frame_done, o_frame_avail, o_sync_err}, {1'b1, (i == 14), (i == 14), 1'b0});
            end
        end
        o_w_valid = 1'b0; o_w_sof = 1'b0;
        o_r_en = 1'b1; o_r_add = 4'd15;
        @(posedge clk);
        #1;
        checks++;
        if ({o_r_valid, o_r_data} !== {1'b1, 12'h000}) begin
            errors++;
            $display("FAIL t5_out_of_range got %b/%h required 1/000", o_r_valid, o_r_data);
        end
        for (int i = 0; i < 15; i += 7) begin
            o_r_add = 4'(i);
            @(posedge clk);
            #1;
            checks++;
            if (o_r_data !== PW'(12'h700 + i)) begin
                errors++;
                $display("FAIL t5_read addr%0d got %h required %h", i, o_r_data, PW'(12'h700 + i));
            end
        end
        // Second frame with no marker: must start at address 0 because the counter wrapped.
        o_r_en = 1'b0;
        for (int i = 0; i < 15; i++) begin
            o_w_valid = 1'b1; o_w_sof = 1'b0; o_w_data = PW'(12'h800 + i);
            o_r_release = (i == 14);
            @(posedge clk);
            #1;
        end
        o_w_valid = 1'b0; o_r_release = 1'b0;
        checks++;
        if ({o_frame_done, o_frame_avail, o_w_ready} !== 3'b111) begin
            errors++;
            $display("FAIL t5_second_swap got %b required 111", {o_frame_done, o_frame_avail, o_w_ready});
        end
        o_r_en = 1'b1; o_r_add = 4'd0;
        @(posedge clk);
        #1;
        checks++;
        if (o_r_data !== 12'h800) begin
            errors++;
            $display("FAIL t5_wrap addr0 got %h required 800", o_r_data);
        end
        o_r_add = 4'd14;
        @(posedge clk);
        #1;
        checks++;
        if (o_r_data !== 12'h80E) begin
            errors++;
            $display("FAIL t5_wrap addr14 got %h required 80e", o_r_data);
        end
        o_r_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        o_w_valid = 1'b0; o_w_sof = 1'b0; o_w_data = '0;
        o_r_en = 1'b0; o_r_add = '0; o_r_release = 1'b0;
        model_reset();
        test_reset();
        test_single_frame();
        test_full_hold();
        test_release_on_last();
        test_sync_err();
        test_random();
        test_async_reset();
        test_odd_depth();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
